// File: rtl/lab01_sweep_if.sv
// Signal bundle between the sweep sequencer and the board / function-block side.
// The master side drives start, the unit result and the table read index.
interface lab01_sweep_if;
  logic       start;
  logic [3:0] abcd;
  logic [3:0] wxyz;
  logic       busy;
  logic       done;
  logic [6:0] ones_count;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;

  modport master (
    output start, wxyz, rd_addr,
    input  abcd, busy, done, ones_count, rd_data
  );

  modport slave (
    input  start, wxyz, rd_addr,
    output abcd, busy, done, ones_count, rd_data
  );
endinterface

// File: rtl/lab01_sweep_ctrl.sv
// Truth-table sweep sequencer: drives all 16 input vectors into a 4-in/4-out
// logic unit, captures every result into a readable table and counts the ones.
module lab01_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  lab01_sweep_if.slave sweep
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Reload value for the settle counter; unused when SETTLE is zero.
  localparam logic [3:0] WAIT_INIT = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] idx;
  logic [3:0] idx_nxt;
  logic [3:0] wcnt;
  logic [3:0] wcnt_nxt;
  logic [3:0] abcd_r;
  logic [3:0] abcd_nxt;
  logic [6:0] ones_r;
  logic [6:0] ones_nxt;
  logic       busy_r;
  logic       done_r;
  logic       cap_en;
  logic [3:0] mem [16];

  function automatic logic [6:0] popcount4(input logic [3:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wcnt_nxt  = wcnt;
    abcd_nxt  = abcd_r;
    ones_nxt  = ones_r;
    cap_en    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        abcd_nxt = '0;
        if (sweep.start) begin
          state_nxt = ST_DRIVE;
          idx_nxt   = '0;
          ones_nxt  = '0;
        end
      end
      ST_DRIVE: begin
        if (SETTLE == 0) begin
          state_nxt = ST_CAPTURE;
        end else begin
          wcnt_nxt  = WAIT_INIT;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt == 4'd0) begin
          state_nxt = ST_CAPTURE;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
        end
      end
      ST_CAPTURE: begin
        cap_en   = 1'b1;
        ones_nxt = ones_r + popcount4(sweep.wxyz);
        // The last vector exits to DONE, so idx never wraps.
        if (idx == 4'd15) begin
          state_nxt = ST_DONE;
        end else begin
          idx_nxt   = idx + 4'd1;
          abcd_nxt  = idx + 4'd1;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DONE: begin
        abcd_nxt  = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      wcnt   <= '0;
      abcd_r <= '0;
      ones_r <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      wcnt   <= wcnt_nxt;
      abcd_r <= abcd_nxt;
      ones_r <= ones_nxt;
      busy_r <= (state_nxt != ST_IDLE);
      done_r <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= '0;
      end
    end else if (cap_en) begin
      mem[idx] <= sweep.wxyz;
    end
  end

  assign sweep.abcd       = abcd_r;
  assign sweep.busy       = busy_r;
  assign sweep.done       = done_r;
  assign sweep.ones_count = ones_r;
  assign sweep.rd_data    = mem[sweep.rd_addr];

endmodule

// File: tb/tb_lab01_sweep_ctrl.sv
// Bench for lab01_sweep_ctrl: three instances (SETTLE 1, 0, 3) share clk/rst/start,
// each fed by its own selectable logic-unit model and tracked by a timing model.
module tb_lab01_sweep_ctrl;
  localparam int NDUT = 3;
  localparam int ST0  = 1;
  localparam int ST1  = 0;
  localparam int ST2  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic [1:0]  mode [NDUT] = '{2'd0, 2'd0, 2'd0};
  logic [63:0] lut  [NDUT] = '{64'd0, 64'd0, 64'd0};
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lab01_sweep_if bus0 ();
  lab01_sweep_if bus1 ();
  lab01_sweep_if bus2 ();

  lab01_sweep_ctrl #(.SETTLE(ST0)) dut0 (.clk(clk), .rst(rst), .sweep(bus0));
  lab01_sweep_ctrl #(.SETTLE(ST1)) dut1 (.clk(clk), .rst(rst), .sweep(bus1));
  lab01_sweep_ctrl #(.SETTLE(ST2)) dut2 (.clk(clk), .rst(rst), .sweep(bus2));

  // Logic unit: 0 loopback, 1 invert, 2 constant ones, 3 random truth table.
  function automatic logic [3:0] unit_fn(input logic [1:0] m, input logic [63:0] l,
                                         input logic [3:0] v);
    case (m)
      2'd0:    return v;
      2'd1:    return ~v;
      2'd2:    return 4'hF;
      default: return l[{v, 2'b00} +: 4];
    endcase
  endfunction

  function automatic int settle_of(input int k);
    return (k == 0) ? ST0 : (k == 1) ? ST1 : ST2;
  endfunction

  function automatic int sweep_len(input int k);
    return 1 + 16 * (settle_of(k) + 2);
  endfunction

  function automatic logic [3:0] exp_abcd(input int k, input int tt);
    if (tt == 0) return 4'd0;
    if (tt == sweep_len(k)) return 4'd15;
    return 4'((tt - 1) / (settle_of(k) + 2));
  endfunction

  function automatic logic [3:0] cap_vec(input int k, input int tt);
    return 4'(tt / (settle_of(k) + 2) - 1);
  endfunction

  assign bus0.start = start;
  assign bus1.start = start;
  assign bus2.start = start;
  assign bus0.rd_addr = rd_addr;
  assign bus1.rd_addr = rd_addr;
  assign bus2.rd_addr = rd_addr;
  assign bus0.wxyz = unit_fn(mode[0], lut[0], bus0.abcd);
  assign bus1.wxyz = unit_fn(mode[1], lut[1], bus1.abcd);
  assign bus2.wxyz = unit_fn(mode[2], lut[2], bus2.abcd);

  logic [3:0] abcd_a [NDUT];
  logic [3:0] rd_a   [NDUT];
  logic [6:0] ones_a [NDUT];
  logic       busy_a [NDUT];
  logic       done_a [NDUT];
  assign abcd_a[0] = bus0.abcd;       assign abcd_a[1] = bus1.abcd;       assign abcd_a[2] = bus2.abcd;
  assign rd_a[0]   = bus0.rd_data;    assign rd_a[1]   = bus1.rd_data;    assign rd_a[2]   = bus2.rd_data;
  assign ones_a[0] = bus0.ones_count; assign ones_a[1] = bus1.ones_count; assign ones_a[2] = bus2.ones_count;
  assign busy_a[0] = bus0.busy;       assign busy_a[1] = bus1.busy;       assign busy_a[2] = bus2.busy;
  assign done_a[0] = bus0.done;       assign done_a[1] = bus1.done;       assign done_a[2] = bus2.done;

  // Reference: t = cycles since the accepted start (0 = idle); vector i is
  // captured at the edge closing cycle (i+1)*(SETTLE+2).
  int         t        [NDUT];
  logic [6:0] ones_ref [NDUT];
  logic [3:0] mref     [NDUT][16];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NDUT; k++) begin
        t[k]        <= 0;
        ones_ref[k] <= '0;
        for (int i = 0; i < 16; i++) mref[k][i] <= '0;
      end
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        if (t[k] == 0) begin
          if (start) begin
            t[k]        <= 1;
            ones_ref[k] <= '0;
          end
        end else begin
          if (t[k] % (settle_of(k) + 2) == 0) begin
            mref[k][cap_vec(k, t[k])] <= unit_fn(mode[k], lut[k], cap_vec(k, t[k]));
            ones_ref[k] <= ones_ref[k]
                         + 7'($countones(unit_fn(mode[k], lut[k], cap_vec(k, t[k]))));
          end
          t[k] <= (t[k] == sweep_len(k)) ? 0 : t[k] + 1;
        end
      end
    end
  end

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      check("busy", k, 32'(busy_a[k]), 32'(t[k] != 0));
      check("done", k, 32'(done_a[k]), 32'(t[k] == sweep_len(k)));
      check("abcd", k, 32'(abcd_a[k]), 32'(exp_abcd(k, t[k])));
      check("ones_count", k, 32'(ones_a[k]), 32'(ones_ref[k]));
      check("rd_data", k, 32'(rd_a[k]), 32'(mref[k][rd_addr]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    for (int k = 0; k < NDUT; k++) mode[k] = m;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a[0] | busy_a[1] | busy_a[2]) && n < 400) begin
      cyc();
      n++;
    end
    check("idle_timeout", 0, 32'(n < 400), 32'd1);
  endtask

  task automatic run_sweep(input int k, output int dc);
    start = 1'b1;
    cyc();
    start = 1'b0;
    dc = 1;
    while (!done_a[k] && dc < 400) begin
      cyc();
      dc++;
    end
  endtask

  typedef struct {
    int         k;
    logic [1:0] m;
    int         exp_done;
    logic [6:0] exp_ones;
    logic [3:0] addr;
    logic [3:0] data;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int dc;
    int c;
    int dones;
    int first_done;
    int q [$];

    tbl[0] = '{k: 0, m: 2'd0, exp_done: 49, exp_ones: 7'd32, addr: 4'd9,  data: 4'h9};
    tbl[1] = '{k: 1, m: 2'd1, exp_done: 33, exp_ones: 7'd32, addr: 4'd5,  data: 4'hA};
    tbl[2] = '{k: 2, m: 2'd2, exp_done: 81, exp_ones: 7'd64, addr: 4'd6,  data: 4'hF};
    tbl[3] = '{k: 0, m: 2'd1, exp_done: 49, exp_ones: 7'd32, addr: 4'd0,  data: 4'hF};
    tbl[4] = '{k: 2, m: 2'd0, exp_done: 81, exp_ones: 7'd32, addr: 4'd12, data: 4'hC};
    tbl[5] = '{k: 1, m: 2'd2, exp_done: 33, exp_ones: 7'd64, addr: 4'd3,  data: 4'hF};
    tbl[6] = '{k: 1, m: 2'd1, exp_done: 33, exp_ones: 7'd32, addr: 4'd15, data: 4'h0};

    // Reset state
    cyc();
    cyc();
    for (int k = 0; k < NDUT; k++) begin
      check("rst_busy", k, 32'(busy_a[k]), 32'd0);
      check("rst_done", k, 32'(done_a[k]), 32'd0);
      check("rst_abcd", k, 32'(abcd_a[k]), 32'd0);
      check("rst_ones", k, 32'(ones_a[k]), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      cyc();
      check("rst_mem", 0, 32'(rd_a[0]), 32'd0);
    end

    // Table-driven sweeps
    for (int r = 0; r < 7; r++) begin
      set_mode(tbl[r].m);
      run_sweep(tbl[r].k, dc);
      check("done_cycle", tbl[r].k, 32'(dc), 32'(tbl[r].exp_done));
      check("final_ones", tbl[r].k, 32'(ones_a[tbl[r].k]), 32'(tbl[r].exp_ones));
      wait_idle();
      rd_addr = tbl[r].addr;
      cyc();
      check("tbl_rd_data", tbl[r].k, 32'(rd_a[tbl[r].k]), 32'(tbl[r].data));
      for (int i = 0; i < 16; i++) begin
        rd_addr = 4'(i);
        cyc();
        check("readback", tbl[r].k, 32'(rd_a[tbl[r].k]),
              32'(unit_fn(tbl[r].m, 64'd0, 4'(i))));
      end
    end

    // Start pulses while busy are ignored
    set_mode(2'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    c = 1;
    dones = 0;
    first_done = 0;
    while (c < 70) begin
      if (done_a[0]) begin
        dones++;
        first_done = c;
      end
      if (c == 31) check("busy_start_ones", 0, 32'(ones_a[0]), 32'd15);
      if (c == 55) check("busy_start_noqueue", 0, 32'(busy_a[0]), 32'd0);
      start = (c == 10) || (c >= 30 && c <= 32);
      cyc();
      c++;
    end
    start = 1'b0;
    check("busy_start_dones", 0, 32'(dones), 32'd1);
    check("busy_start_done_cycle", 0, 32'(first_done), 32'd49);
    wait_idle();

    // Async reset mid-WAIT of vector 7
    rd_addr = 4'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    c = 1;
    while (c < 23) begin
      cyc();
      c++;
    end
    check("pre_rst_abcd", 0, 32'(abcd_a[0]), 32'd7);
    check("pre_rst_mem3", 0, 32'(rd_a[0]), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_busy", 0, 32'(busy_a[0]), 32'd0);
    check("async_abcd", 0, 32'(abcd_a[0]), 32'd0);
    check("async_ones", 0, 32'(ones_a[0]), 32'd0);
    check("async_done", 0, 32'(done_a[0]), 32'd0);
    check("async_mem", 0, 32'(rd_a[0]), 32'd0);
    cyc();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_a[0]) dones++;
      cyc();
    end
    check("rst_no_done", 0, 32'(dones), 32'd0);
    run_sweep(0, dc);
    check("post_rst_done_cycle", 0, 32'(dc), 32'd49);
    check("post_rst_ones", 0, 32'(ones_a[0]), 32'd32);
    wait_idle();

    // start held high: back-to-back sweeps
    start = 1'b1;
    cyc();
    c = 1;
    while (c <= 110) begin
      if (done_a[0]) q.push_back(c);
      if (c == 50) check("held_ones_idle", 0, 32'(ones_a[0]), 32'd32);
      if (c == 51) check("held_ones_restart", 0, 32'(ones_a[0]), 32'd0);
      if (c == 99) start = 1'b0;
      cyc();
      c++;
    end
    check("held_done_n", 0, 32'(q.size()), 32'd2);
    check("held_done_1", 0, 32'((q.size() > 0) ? q[0] : -1), 32'd49);
    check("held_done_2", 0, 32'((q.size() > 1) ? q[1] : -1), 32'd99);
    wait_idle();

    // Randomized traffic against the reference model
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < NDUT; k++) begin
        mode[k] = 2'($urandom_range(0, 3));
        lut[k]  = {$urandom, $urandom};
      end
      for (int i = 0; i < 120; i++) begin
        start   = ($urandom_range(0, 7) == 0);
        rd_addr = 4'($urandom_range(0, 15));
        rst     = (it % 5 == 4) && (i == 40 + (it % 3) * 7);
        cyc();
      end
      start = 1'b0;
      rst   = 1'b0;
      wait_idle();
      for (int k = 0; k < NDUT; k++) begin
        check("rand_ones", k, 32'(ones_a[k]), 32'(ones_ref[k]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
